// File: rtl/multi_timer_pkg.sv
// Shared constants, control payload and parameter helpers for the multi_timer peripheral.
// MULTI_TIMER_CAPTURE_EN adds one address bit for the per-channel capture words.
package multi_timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_START    = 0;
    localparam int unsigned CTRL_PERIODIC = 1;
    localparam int unsigned CTRL_IRQ_EN   = 2;
    localparam int unsigned CTRL_STOP     = 3;

`ifdef MULTI_TIMER_CAPTURE_EN
    localparam int unsigned CAP_AW = 1;
`else
    localparam int unsigned CAP_AW = 0;
`endif

    typedef struct packed {
        logic stop;
        logic irq_en;
        logic periodic;
        logic start;
    } ctrl_t;

    function automatic int unsigned calc_div(input int unsigned simulacion,
                                             input int unsigned sim_div,
                                             input int unsigned clk_hz,
                                             input int unsigned tick_hz);
        return (simulacion != 0) ? sim_div : clk_hz / tick_hz;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned n_ch);
        int unsigned aw;
        aw = $clog2(n_ch) + 2;
        return (aw < 3) ? 3 : aw;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, down-counter, one-shot/periodic mode and sticky done flag.
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_we,
    input  logic             load_we,
    input  logic             status_we,
    input  logic [31:0]      wdata,
    output logic [CNT_W-1:0] load,
    output logic [CNT_W-1:0] count,
    output logic             periodic,
    output logic             irq_en,
    output logic             running,
    output logic             done
);

    localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    ctrl_t         cw;
    logic [PW-1:0] presc;

    assign cw = '{stop:     wdata[CTRL_STOP],
                  irq_en:   wdata[CTRL_IRQ_EN],
                  periodic: wdata[CTRL_PERIODIC],
                  start:    wdata[CTRL_START]};

    // Later assignments win: a done set on the same edge overrides the W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load     <= '0;
            count    <= '0;
            presc    <= '0;
            periodic <= 1'b0;
            irq_en   <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load_we) begin
                load <= CNT_W'(wdata);
            end
            if (status_we && wdata[0]) begin
                done <= 1'b0;
            end
            if (ctrl_we) begin
                periodic <= cw.periodic;
                irq_en   <= cw.irq_en;
            end
            if (ctrl_we && cw.stop) begin
                running <= 1'b0;
            end else if (ctrl_we && cw.start) begin
                count   <= load;
                presc   <= '0;
                running <= (load != '0);
                done    <= (load == '0);
            end else if (running) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    if (count > CNT_W'(1)) begin
                        count <= count - CNT_W'(1);
                    end else begin
                        done <= 1'b1;
                        if (periodic && (load != '0)) begin
                            count <= load;
                        end else begin
                            count   <= '0;
                            running <= 1'b0;
                        end
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// N-channel memory-mapped tick timer: reset synchroniser, address decode and registered read mux.
// Define MULTI_TIMER_CAPTURE_EN to add per-channel CAPTURE words at address N_CH*4+ch.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned CLK_HZ     = 10_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned SIMULACION = 0,
    parameter int unsigned SIM_DIV    = 10
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                we,
    input  logic [calc_aw(N_CH)+CAP_AW-1:0]     addr,
    input  logic [31:0]                         wdata,
    output logic [31:0]                         rdata,
    output logic [N_CH-1:0]                     done_o,
    output logic                                irq_o
);

    localparam int unsigned AW  = calc_aw(N_CH) + CAP_AW;
    localparam int unsigned CW  = AW - 2;
    localparam int unsigned DIV = calc_div(SIMULACION, SIM_DIV, CLK_HZ, TICK_HZ);

    logic [1:0]       rst_sync;
    logic             rst_n;
    logic [CW-1:0]    word_ch;
    logic [1:0]       word_reg;
    logic [CNT_W-1:0] load_q  [N_CH];
    logic [CNT_W-1:0] count_q [N_CH];
    logic [N_CH-1:0]  periodic_q;
    logic [N_CH-1:0]  irq_en_q;
    logic [N_CH-1:0]  running_q;
    logic [N_CH-1:0]  done_q;
    logic [31:0]      rd_c;

    // Assert asynchronously, release on the second clk edge after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    assign word_ch  = addr[AW-1:2];
    assign word_reg = addr[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = we && (word_ch == CW'(i));

        multi_timer_channel #(
            .CNT_W (CNT_W),
            .DIV   (DIV)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .ctrl_we   (sel && (word_reg == REG_CTRL)),
            .load_we   (sel && (word_reg == REG_LOAD)),
            .status_we (sel && (word_reg == REG_STATUS)),
            .wdata     (wdata),
            .load      (load_q[i]),
            .count     (count_q[i]),
            .periodic  (periodic_q[i]),
            .irq_en    (irq_en_q[i]),
            .running   (running_q[i]),
            .done      (done_q[i])
        );
    end

`ifdef MULTI_TIMER_CAPTURE_EN
    logic [CNT_W-1:0] capture_q [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_cap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                capture_q[i] <= '0;
            end else if (we && (addr == AW'(N_CH * 4 + i))) begin
                capture_q[i] <= count_q[i];
            end
        end
    end
`endif

    // Non-existent channels and unmapped words read as zero.
    always_comb begin
        rd_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (word_ch == CW'(i)) begin
                case (word_reg)
                    REG_CTRL:   rd_c = 32'({irq_en_q[i], periodic_q[i], running_q[i]});
                    REG_LOAD:   rd_c = 32'(load_q[i]);
                    REG_COUNT:  rd_c = 32'(count_q[i]);
                    REG_STATUS: rd_c = 32'(done_q[i]);
                    default:    rd_c = '0;
                endcase
            end
`ifdef MULTI_TIMER_CAPTURE_EN
            if (addr == AW'(N_CH * 4 + i)) begin
                rd_c = 32'(capture_q[i]);
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= rd_c;
        end
    end

    assign done_o = done_q;
    assign irq_o  = |(done_q & irq_en_q);

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (default build, SIMULACION=1, SIM_DIV=10) against a time-based model.
module tb_multi_timer;

    localparam int unsigned N_CH = 4;
    localparam int unsigned AW   = 4;
    localparam int          DIV  = 10;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            we;
    logic [AW-1:0]   addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;
    logic [N_CH-1:0] done_o;
    logic            irq_o;

    multi_timer #(
        .N_CH       (N_CH),
        .CNT_W      (32),
        .CLK_HZ     (10_000_000),
        .TICK_HZ    (1),
        .SIMULACION (1),
        .SIM_DIV    (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done_o  (done_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: a running channel is described by the edge it (re)started and its load;
    // remaining count and expiry edge follow by arithmetic on elapsed cycles.
    logic [31:0] m_load      [N_CH];
    bit          m_run       [N_CH];
    bit          m_per       [N_CH];
    bit          m_ie        [N_CH];
    bit          m_done      [N_CH];
    int          m_seg_start [N_CH];
    int          m_seg_load  [N_CH];
    int          m_frozen    [N_CH];
    logic [31:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int cur_cnt(input int c, input int e);
        if (m_run[c]) return m_seg_load[c] - (e - m_seg_start[c]) / DIV;
        return m_frozen[c];
    endfunction

    function automatic logic [N_CH-1:0] exp_done();
        logic [N_CH-1:0] v;
        v = '0;
        for (int c = 0; c < N_CH; c++) v[c] = m_done[c];
        return v;
    endfunction

    function automatic logic exp_irq();
        logic v;
        v = 1'b0;
        for (int c = 0; c < N_CH; c++) v = v | (m_done[c] & m_ie[c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_load[c] = '0; m_run[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_done[c] = 0;
            m_seg_start[c] = 0; m_seg_load[c] = 0; m_frozen[c] = 0;
        end
    endtask

    task automatic model_edge(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        int         ch;
        logic [1:0] r;
        ch = int'(a[3:2]);
        r  = a[1:0];
        cyc++;
        case (r)
            2'd0:    exp_rd = {29'b0, m_ie[ch], m_per[ch], m_run[ch]};
            2'd1:    exp_rd = m_load[ch];
            2'd2:    exp_rd = 32'(cur_cnt(ch, cyc - 1));
            default: exp_rd = {31'b0, m_done[ch]};
        endcase
        for (int c = 0; c < N_CH; c++) begin
            bit wr;
            bit expire;
            bit per0;
            wr     = w && (ch == c);
            per0   = m_per[c];
            expire = m_run[c] && (cyc == m_seg_start[c] + m_seg_load[c] * DIV);
            if (wr && r == 2'd3 && d[0]) m_done[c] = 0;
            if (wr && r == 2'd0) begin
                m_per[c] = d[1];
                m_ie[c]  = d[2];
            end
            if (wr && r == 2'd0 && d[3]) begin
                if (m_run[c]) begin
                    m_frozen[c] = cur_cnt(c, cyc - 1);
                    m_run[c]    = 0;
                end
            end else if (wr && r == 2'd0 && d[0]) begin
                if (m_load[c] != 0) begin
                    m_seg_start[c] = cyc;
                    m_seg_load[c]  = int'(m_load[c]);
                    m_run[c]       = 1;
                    m_done[c]      = 0;
                end else begin
                    m_run[c]    = 0;
                    m_frozen[c] = 0;
                    m_done[c]   = 1;
                end
            end else if (expire) begin
                m_done[c] = 1;
                if (per0 && m_load[c] != 0) begin
                    m_seg_start[c] = cyc;
                    m_seg_load[c]  = int'(m_load[c]);
                end else begin
                    m_run[c]    = 0;
                    m_frozen[c] = 0;
                end
            end
            if (wr && r == 2'd1) m_load[c] = d;
        end
    endtask

    task automatic tick(input logic w, input logic [AW-1:0] a, input logic [31:0] d);
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        chk("done_o", 32'(done_o), 32'(exp_done()));
        chk("irq_o",  32'(irq_o),  32'(exp_irq()));
        chk("rdata",  rdata,       exp_rd);
    endtask

    task automatic wr(input int c, input int r, input logic [31:0] d);
        tick(1'b1, {2'(c), 2'(r)}, d);
    endtask

    task automatic idle();
        tick(1'b0, AW'($urandom), $urandom);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int r;
        reset_n = 1'b1;
        we      = 1'b0;
        addr    = '0;
        wdata   = '0;
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_irq",  32'(irq_o),  32'd0);
        chk("reset_rdata", rdata,      32'd0);
        #30 reset_n = 1'b1;
        repeat (3) idle();

        // One-shot ch0, LOAD=3: done exactly 30 edges after START.
        wr(0, 1, 3);
        wr(0, 0, 1);
        t = cyc;
        run_to(t + 29);
        chk("oneshot_early", 32'(done_o[0]), 32'd0);
        run_to(t + 30);
        chk("oneshot_done", 32'(done_o[0]), 32'd1);
        tick(1'b0, 4'h0, 32'd0);
        chk("oneshot_running", 32'(rdata[0]), 32'd0);
        tick(1'b0, 4'h2, 32'd0);
        chk("oneshot_count", rdata, 32'd0);

        // Periodic ch1 with irq, W1C, then STOP.
        wr(1, 1, 2);
        wr(1, 0, 7);
        t = cyc;
        run_to(t + 20);
        chk("per_done1", 32'(done_o[1]), 32'd1);
        chk("per_irq1",  32'(irq_o),     32'd1);
        run_to(t + 24);
        wr(1, 3, 1);
        chk("per_w1c",     32'(done_o[1]), 32'd0);
        chk("per_w1c_irq", 32'(irq_o),     32'd0);
        run_to(t + 40);
        chk("per_done2", 32'(done_o[1]), 32'd1);
        run_to(t + 44);
        wr(1, 0, 14);
        run_to(t + 49);
        wr(1, 3, 1);
        run_to(t + 60);
        chk("per_stopped", 32'(done_o[1]), 32'd0);

        // W1C on the same edge done sets: done stays set.
        wr(0, 1, 1);
        wr(0, 0, 1);
        t = cyc;
        run_to(t + 9);
        wr(0, 3, 1);
        chk("w1c_vs_set", 32'(done_o[0]), 32'd1);

        // START with LOAD=0, then a restart of ch2.
        wr(3, 1, 0);
        wr(3, 0, 1);
        chk("load0_done", 32'(done_o[3]), 32'd1);
        tick(1'b0, 4'hC, 32'd0);
        chk("load0_running", 32'(rdata[0]), 32'd0);
        wr(2, 1, 5);
        wr(2, 0, 1);
        t = cyc;
        run_to(t + 19);
        wr(2, 0, 1);
        run_to(t + 50);
        chk("restart_no_early", 32'(done_o[2]), 32'd0);
        run_to(t + 70);
        chk("restart_done", 32'(done_o[2]), 32'd1);

        // Four channels started on consecutive edges, irq enabled on ch0 and ch2.
        for (int c = 0; c < 4; c++) wr(c, 1, 32'(c + 1));
        wr(0, 0, 5);
        t = cyc;
        wr(1, 0, 1);
        wr(2, 0, 5);
        wr(3, 0, 1);
        run_to(t + 20);
        chk("multi_t20", 32'(done_o), 32'h1);
        run_to(t + 21);
        chk("multi_t21", 32'(done_o), 32'h3);
        run_to(t + 43);
        chk("multi_all", 32'(done_o), 32'hF);
        wr(0, 3, 1);
        wr(2, 3, 1);
        chk("multi_irq_off", 32'(irq_o),  32'd0);
        chk("multi_left",    32'(done_o), 32'hA);

        // Randomised register traffic.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0:       wr(int'($urandom_range(0, 3)), r, 32'($urandom_range(0, 15)));
                    1:       wr(int'($urandom_range(0, 3)), r, 32'($urandom_range(0, 6)));
                    2:       wr(int'($urandom_range(0, 3)), r, $urandom);
                    default: wr(int'($urandom_range(0, 3)), r, 32'($urandom_range(0, 1)));
                endcase
            end else begin
                idle();
            end
        end

        // Asynchronous reset between edges while a periodic channel is counting.
        wr(0, 1, 5);
        wr(0, 0, 7);
        t = cyc;
        run_to(t + 55);
        chk("pre_reset_irq", 32'(irq_o), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_done",  32'(done_o), 32'd0);
        chk("async_irq",   32'(irq_o),  32'd0);
        chk("async_rdata", rdata,       32'd0);
        we = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        repeat (100) idle();
        chk("post_reset_done", 32'(done_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
